// File: rtl/udma_hyper_busy_mc.sv
// rtl/udma_hyper_busy_mc.sv - per-channel busy/EOT tracker for the HyperBus uDMA
// Optional ISSUED timeout with ERR pulse: define UDMA_HYPER_BUSY_TIMEOUT_EN
module udma_hyper_busy_mc #(
  parameter int N_CH        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            sys_clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] running_trans_sys_i,
  input  logic [N_CH-1:0] proc_id_sys_i,
  input  logic [N_CH-1:0] running_trans_phy_i,
  output logic [N_CH-1:0] busy_o,
  output logic            busy_any_o,
  output logic [N_CH-1:0] evt_eot_o,
  output logic [N_CH-1:0] evt_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUED,
    ST_BUSY,
    ST_END,
    ST_ERR
  } state_e;

  if (N_CH < 1 || N_CH > 8 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("udma_hyper_busy_mc: illegal parameter value");
  end

  logic [N_CH-1:0] phy_s;
  logic [N_CH-1:0] r_busy;
  logic [N_CH-1:0] busy_d_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q, state_d;
    logic                   r_busy_q;

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], running_trans_phy_i[c]};
      end
    end

    assign phy_s[c] = sync_q[SYNC_STAGES-1];

`ifdef UDMA_HYPER_BUSY_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;
    logic          timeout;

    assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Restarts on every entry to ISSUED, including BUSY -> ISSUED re-issues
    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (state_q != ST_ISSUED && state_d == ST_ISSUED) begin
        cnt_q <= '0;
      end else if (state_q == ST_ISSUED) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign evt_err_o[c] = (state_q == ST_ERR);
`else
    logic timeout;
    assign timeout      = 1'b0;
    assign evt_err_o[c] = 1'b0;
`endif

    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_IDLE: begin
          if (running_trans_sys_i[c]) state_d = ST_ISSUED;
        end
        ST_ISSUED: begin
          // A PHY start seen in the timeout cycle still wins
          if (phy_s[c])     state_d = ST_BUSY;
          else if (timeout) state_d = ST_ERR;
        end
        ST_BUSY: begin
          if (!phy_s[c] && !proc_id_sys_i[c]) begin
            state_d = running_trans_sys_i[c] ? ST_ISSUED : ST_END;
          end
        end
        ST_END:  state_d = ST_IDLE;
        ST_ERR:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q  <= ST_IDLE;
        r_busy_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        r_busy_q <= (state_d != ST_IDLE);
      end
    end

    assign r_busy[c] = r_busy_q;
  end

  assign busy_o     = rst_ni ? (r_busy | running_trans_sys_i) : '0;
  assign busy_any_o = |busy_o;

  // busy_d is cleared by reset, so neither reset edge can fake a falling busy
  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_d_q <= '0;
    end else begin
      busy_d_q <= busy_o;
    end
  end

  assign evt_eot_o = busy_d_q & ~busy_o;

endmodule

// File: doc/udma_hyper_busy_mc.md
UDMA_HYPER_BUSY_MC -- requirements
Module: udma_hyper_busy_mc

Interface
REQ-001 SHALL have parameter N_CH, default 2, meaning the number of independent transfer channels tracked (1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth for PHY status bits (legal values 2..4).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the maximum number of cycles spent in ISSUED before a timeout (legal values ≥ 2).
REQ-004 SHALL have port sys_clk_i  in  1  system clock; it is the block's only clock, and all flops are clocked on its rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port running_trans_sys_i  in  N_CH  per-channel flag: transfer pending/launched in the sys domain.
REQ-007 SHALL have port proc_id_sys_i  in  N_CH  per-channel flag: sys domain still owns the channel; this blocks completion.
REQ-008 SHALL have port running_trans_phy_i  in  N_CH  per-channel PHY activity flag, asynchronous to sys_clk_i, already gated with the PHY process id.
REQ-009 SHALL have port busy_o  out  N_CH  per-channel busy.
REQ-010 SHALL have port busy_any_o  out  1  OR of busy_o.
REQ-011 SHALL have port evt_eot_o  out  N_CH  per-channel end-of-transfer pulse.
REQ-012 SHALL have port evt_err_o  out  N_CH  per-channel timeout error pulse.

Function
REQ-013 SHALL pass each running_trans_phy_i bit through its own SYNC_STAGES-deep flop chain; phy_s[c] is the last stage of that chain.
REQ-014 SHALL run one independent FSM per channel with states IDLE, ISSUED, BUSY, END, ERR, and SHALL keep a registered r_busy[c] flag per channel.
REQ-015 In IDLE, SHALL go to ISSUED and set r_busy=1 if running_trans_sys_i[c]=1; otherwise SHALL stay in IDLE with r_busy=0.
REQ-016 In ISSUED, SHALL go to BUSY if phy_s[c]=1; r_busy SHALL stay 1.
REQ-017 In BUSY, when phy_s[c]=0 and proc_id_sys_i[c]=0, SHALL go to ISSUED if running_trans_sys_i[c]=1 and to END otherwise; it SHALL stay in BUSY in all other cases, and r_busy SHALL stay 1.
REQ-018 END SHALL last one cycle, then go to IDLE with r_busy=0.
REQ-019 SHALL drive busy_o[c] = r_busy[c] | running_trans_sys_i[c] while rst_ni=1, and 0 while rst_ni=0.
REQ-020 SHALL drive evt_eot_o[c] = busy_d[c] & ~busy_o[c], where busy_d is busy_o registered once; this gives exactly one pulse per 1->0 busy edge.
REQ-021 SHALL keep busy_any_o and evt_eot_o combinational; all other state SHALL be registered.
REQ-022 SHALL keep channels fully independent; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.
REQ-023 If running_trans_sys_i[c] is held high through END, busy_o SHALL stay 1 and no EOT pulse SHALL be produced.
REQ-024 A running_trans_phy_i pulse shorter than one sys_clk_i period SHALL NOT be guaranteed to be captured; the producer SHALL hold the flag for at least 2 sys_clk_i cycles.

Reset
REQ-025 While rst_ni=0, SHALL put every FSM in IDLE and clear r_busy, busy_d, synchroniser flops and timeout counters, and SHALL hold busy_o, busy_any_o, evt_eot_o and evt_err_o at 0.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer silently, with no EOT or ERR pulse on reset assertion or release.

Configuration
REQ-027 With macro UDMA_HYPER_BUSY_TIMEOUT_EN defined, each channel SHALL have a counter of width $clog2(TIMEOUT_CYC+1), cleared on entry to ISSUED and incremented each cycle spent in ISSUED.
REQ-028 With the macro defined, when the counter equals TIMEOUT_CYC-1 and phy_s[c]=0, the FSM SHALL go to ERR; phy_s[c]=1 in that same cycle SHALL win and the FSM SHALL go to BUSY.
REQ-029 ERR SHALL last one cycle, with evt_err_o[c]=1 in that cycle, then go to IDLE with r_busy=0; the EOT pulse follows under REQ-020.
REQ-030 Without the macro, SHALL omit the counters and ERR, ISSUED SHALL wait indefinitely, and evt_err_o SHALL be tied to 0 with the port kept.

Verification
REQ-031 Ch0 running_trans_sys_i 1 for 3 cycles, phy pulse 6 cycles from cycle 2 -> busy_o[0]=1 from cycle 0, one evt_eot_o[0] pulse 2 cycles after phy_s falls, ch1 stays 0.
REQ-032 Ch0 BUSY with proc_id_sys_i=1 held for 10 cycles after phy drops -> busy_o[0] stays 1 until proc_id_sys_i falls, then EOT 2 cycles later.
REQ-033 Back-to-back run: running_trans_sys_i rises again while ch0 is in BUSY -> BUSY to ISSUED to BUSY with no EOT between the two transfers.
REQ-034 Timeout (macro on, TIMEOUT_CYC=8): issue with phy held 0 -> evt_err_o[0] pulse 8 cycles after ISSUED entry, evt_eot_o[0] next cycle; macro off -> busy held indefinitely.
REQ-035 Reset asserted while ch0 and ch1 are both BUSY -> all outputs 0 immediately, no pulses after release.
REQ-036 N_CH=4, SYNC_STAGES=3, all four channels complete in the same cycle -> four simultaneous EOT pulses and busy_any_o falls in that cycle.
